// File: rtl/ss_mac_pkg.sv
// Shared types and constants for the stochastic-symbol MAC sequencer.
// Holds the FSM state encoding, LFSR taps and per-input seeds.
package ss_mac_pkg;

    localparam int NUM_IN     = 8;
    localparam int RN_W       = 8;
    localparam int MAX_ROUNDS = 8;

    // Taps at bits 7,5,4,3 of the Fibonacci LFSR.
    localparam logic [RN_W-1:0] LFSR_TAPS = 8'hB8;

    // SEEDS[i] seeds the LFSR feeding MAC input i.
    localparam logic [NUM_IN-1:0][RN_W-1:0] SEEDS = {
        8'hC3, 8'hA5, 8'h8E, 8'h71,
        8'h5C, 8'h3A, 8'h1D, 8'h01
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE
    } state_t;

    // Clamp the requested round count so the 10-bit sum cannot overflow.
    function automatic logic [3:0] sat_rounds(input logic [3:0] n);
        return (n > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : n;
    endfunction

endpackage

// File: rtl/ss_mac_sequencer_lfsr.sv
// 8-bit Fibonacci LFSR with enable and all-zero lockup recovery.
// One instance per MAC input; the stream persists across jobs.
module ss_lfsr8
    import ss_mac_pkg::*;
#(
    parameter logic [RN_W-1:0] SEED = 8'h01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [RN_W-1:0] value
);

    logic feedback;

    assign feedback = ^(value & LFSR_TAPS);

    // Reseed on reset or lockup, otherwise shift only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (value == '0) begin
            value <= SEED;
        end else if (en) begin
            value <= {value[RN_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/ss_mac_sequencer.sv
// Sequencer for the 4-bit stochastic-symbol MAC: clears the MAC,
// steps sel through R rounds of 8 inputs and captures the sum.
module ss_mac_sequencer
    import ss_mac_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      num_rounds,
    input  logic [9:0]      z_in,
    output logic            mac_rst_n,
    output logic [2:0]      sel,
    output logic [RN_W-1:0] x_randnum_0,
    output logic [RN_W-1:0] x_randnum_1,
    output logic [RN_W-1:0] x_randnum_2,
    output logic [RN_W-1:0] x_randnum_3,
    output logic [RN_W-1:0] x_randnum_4,
    output logic [RN_W-1:0] x_randnum_5,
    output logic [RN_W-1:0] x_randnum_6,
    output logic [RN_W-1:0] x_randnum_7,
    output logic            busy,
    output logic [9:0]      result,
    output logic            done
);

    state_t          state;
    state_t          next_state;
    logic [5:0]      cnt;
    logic [3:0]      rounds;
    logic [3:0]      eff_rounds;
    logic [6:0]      run_last;
    logic            go;
    logic            run_en;
    logic            clr_q;
    logic [RN_W-1:0] rn [NUM_IN];

    assign eff_rounds = sat_rounds(num_rounds);
    assign go         = start && (eff_rounds != 4'd0);
    assign run_last   = {rounds, 3'b000} - 7'd1;
    assign run_en     = (state == S_RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and registered-state output decode.
    always_comb begin
        next_state = state;
        busy       = 1'b1;
        sel        = 3'd0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (go) begin
                    next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                next_state = S_RUN;
            end
            S_RUN: begin
                sel = cnt[2:0];
                if ({1'b0, cnt} == run_last) begin
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Round latch, RUN cycle counter, result capture and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rounds <= 4'd0;
            cnt    <= 6'd0;
            result <= 10'd0;
            done   <= 1'b0;
        end else begin
            if (state == S_IDLE && go) begin
                rounds <= eff_rounds;
            end
            cnt  <= run_en ? cnt + 6'd1 : 6'd0;
            done <= (state == S_CAPTURE);
            if (state == S_CAPTURE) begin
                result <= z_in;
            end
        end
    end

    // MAC clear strobe, registered so it is glitch-free at the MAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_q <= 1'b1;
        end else begin
            clr_q <= (next_state == S_CLEAR);
        end
    end

    assign mac_rst_n = ~clr_q;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_lfsr
        ss_lfsr8 #(
            .SEED (SEEDS[i])
        ) u_lfsr (
            .clk   (clk),
            .rst   (rst),
            .en    (run_en),
            .value (rn[i])
        );
    end

    assign x_randnum_0 = rn[0];
    assign x_randnum_1 = rn[1];
    assign x_randnum_2 = rn[2];
    assign x_randnum_3 = rn[3];
    assign x_randnum_4 = rn[4];
    assign x_randnum_5 = rn[5];
    assign x_randnum_6 = rn[6];
    assign x_randnum_7 = rn[7];

endmodule

// File: tb/tb_ss_mac_sequencer.sv
// Directed bench for ss_mac_sequencer: timing of one job, a
// table of round counts, mid-job reset and held start.
module tb_ss_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] num_rounds = 4'd0;
    logic [9:0] z_in = 10'd0;
    logic       mac_rst_n;
    logic [2:0] sel;
    logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic       busy;
    logic [9:0] result;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] nr;
        logic [9:0] z;
        int         lat;
        int         busy_n;
        int         clr_n;
        bit         job;
    } vec_t;

    vec_t vecs [6];

    ss_mac_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_rounds  (num_rounds),
        .z_in        (z_in),
        .mac_rst_n   (mac_rst_n),
        .sel         (sel),
        .x_randnum_0 (x0),
        .x_randnum_1 (x1),
        .x_randnum_2 (x2),
        .x_randnum_3 (x3),
        .x_randnum_4 (x4),
        .x_randnum_5 (x5),
        .x_randnum_6 (x6),
        .x_randnum_7 (x7),
        .busy        (busy),
        .result      (result),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launch one job and observe it until done or a cycle budget.
    task automatic run_job(input logic [3:0] nr, input logic [9:0] z,
                           input logic [9:0] prev, output int lat,
                           output int busy_n, output int clr_n);
        z_in = z;
        num_rounds = nr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_n = 0;
        clr_n = 0;
        for (int k = 1; k <= 90; k++) begin
            if (k <= 2) chk("result_hold", 32'(result), 32'(prev));
            if (done) begin
                lat = k;
                chk("result_done", 32'(result), 32'(z));
                break;
            end
            if (busy) busy_n++;
            if (!mac_rst_n) clr_n++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] xs [5];
        logic [9:0] prev;
        int lat, busy_n, clr_n, ndone;

        xs = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        vecs[0] = '{4'd2,  10'd100,  19, 18, 1, 1'b1};
        vecs[1] = '{4'd12, 10'd960,  67, 66, 1, 1'b1};
        vecs[2] = '{4'd0,  10'd5,     0,  0, 0, 1'b0};
        vecs[3] = '{4'd8,  10'd511,  67, 66, 1, 1'b1};
        vecs[4] = '{4'd3,  10'd0,    27, 26, 1, 1'b1};
        vecs[5] = '{4'd15, 10'd1023, 67, 66, 1, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_mac_rst_n", 32'(mac_rst_n), 32'd0);
        chk("seed0", 32'(x0), 32'h01);
        chk("seed1", 32'(x1), 32'h1D);
        chk("seed2", 32'(x2), 32'h3A);
        chk("seed3", 32'(x3), 32'h5C);
        chk("seed4", 32'(x4), 32'h71);
        chk("seed5", 32'(x5), 32'h8E);
        chk("seed6", 32'(x6), 32'hA5);
        chk("seed7", 32'(x7), 32'hC3);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_mac_rst_n", 32'(mac_rst_n), 32'd1);

        // One round, cycle by cycle; z_in stubs the MAC sum.
        z_in = 10'd347;
        num_rounds = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("j1_busy_k%0d", k), 32'(busy), 32'(k <= 10));
            chk($sformatf("j1_macrst_k%0d", k), 32'(mac_rst_n),
                32'(k != 1));
            chk($sformatf("j1_sel_k%0d", k), 32'(sel),
                (k >= 2 && k <= 9) ? 32'(k - 2) : 32'd0);
            chk($sformatf("j1_done_k%0d", k), 32'(done), 32'(k == 11));
            if (k >= 2 && k <= 6)
                chk($sformatf("j1_x0_k%0d", k), 32'(x0), 32'(xs[k-2]));
            if (k == 1)
                chk("j1_x0_clear_hold", 32'(x0), 32'h01);
            if (k >= 10)
                chk($sformatf("j1_x0_hold_k%0d", k), 32'(x0), 32'h1C);
            if (k == 11)
                chk("j1_result", 32'(result), 32'd347);
            if (k < 11) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("idle_x0_hold", 32'(x0), 32'h1C);

        // Round-count table.
        prev = 10'd347;
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].nr, vecs[i].z, prev, lat, busy_n, clr_n);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i), 32'(busy_n),
                32'(vecs[i].busy_n));
            chk($sformatf("v%0d_clear", i), 32'(clr_n), 32'(vecs[i].clr_n));
            if (vecs[i].job) prev = vecs[i].z;
            @(negedge clk);
        end
        chk("table_result_final", 32'(result), 32'd1023);

        // Reset during RUN cycle 20.
        num_rounds = 4'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_sel", 32'(sel), 32'd0);
        chk("mid_mac_rst_n", 32'(mac_rst_n), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_result", 32'(result), 32'd0);
        @(negedge clk);
        chk("mid_mac_rst_n_held", 32'(mac_rst_n), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_x0_seed", 32'(x0), 32'h01);
        chk("mid_mac_rst_n_rel", 32'(mac_rst_n), 32'd1);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("mid_no_activity", 32'(ndone), 32'd0);

        // Start held high: ignored while busy, re-triggers on done.
        num_rounds = 4'd1;
        z_in = 10'd7;
        start = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) chk("held_clear1", 32'(mac_rst_n), 32'd0);
            if (k == 5) chk("held_no_reclear", 32'(mac_rst_n), 32'd1);
            if (k == 11) begin
                chk("held_done1", 32'(done), 32'd1);
                chk("held_idle_on_done", 32'(busy), 32'd0);
            end
            if (k == 12) begin
                chk("held_clear2", 32'(mac_rst_n), 32'd0);
                chk("held_busy2", 32'(busy), 32'd1);
                chk("held_done_pulse", 32'(done), 32'd0);
            end
            if (k == 22) begin
                chk("held_done2", 32'(done), 32'd1);
                start = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        chk("held_idle_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
